// File: rtl/priority_decoder.sv
// Binary index to one-hot decoder with a valid/ready input handshake.
// Each accepted in-range code drives its line for HOLD cycles, then releases it.
module priority_decoder #(
  parameter int unsigned N_OUT = 8,
  parameter int unsigned W     = 3,
  parameter int unsigned HOLD  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     code,
  output logic [N_OUT-1:0] q,
  output logic             q_valid,
  output logic             err
);

  localparam int unsigned CW      = $clog2(HOLD + 1);
  localparam logic [CW-1:0] CntInit = CW'(HOLD - 1);
  localparam logic [W:0]    NOut    = (W + 1)'(N_OUT);

  typedef enum logic [0:0] {StIdle, StDrive} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_OUT-1:0] q_q, q_d;
  logic             err_q, err_d;
  logic             accept;
  logic             in_range;
  logic [N_OUT-1:0] onehot;

  // Gated by rst_n so the source sees not-ready while reset is held.
  assign in_ready = rst_n & en & (state_q == StIdle);
  assign accept   = in_valid & in_ready;
  assign in_range = {1'b0, code} < NOut;

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      onehot[i] = (code == W'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (in_range) begin
            state_d = StDrive;
            q_d     = onehot;
            cnt_d   = CntInit;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StDrive: begin
        if (!en || (cnt_q == '0)) begin
          state_d = StIdle;
          q_d     = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        q_d     = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      q_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      err_q   <= err_d;
    end
  end

  assign q       = q_q;
  assign q_valid = (state_q == StDrive);
  assign err     = err_q;

endmodule
